// File: rtl/mem_pkg.sv
// Shared types and helper predicates for the data-memory access unit.
package mem_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } mau_state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LW) || (op == LH) || (op == LHU) ||
               (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_subword_store(input mem_op_t op);
        return (op == SH) || (op == SB);
    endfunction

    function automatic logic is_misaligned(input mem_op_t op,
                                           input logic [1:0] lo);
        logic word_op;
        logic half_op;
        word_op = (op == LW) || (op == SW);
        half_op = (op == LH) || (op == LHU) || (op == SH);
        return (word_op && (lo != 2'b00)) || (half_op && lo[0]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: load extract+extend, store lane merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] sdata
);

    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        lb = 8'h00;
        unique case (addr)
            2'd0: lb = word[7:0];
            2'd1: lb = word[15:8];
            2'd2: lb = word[23:16];
            2'd3: lb = word[31:24];
        endcase
        lh = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        ldata = 32'h0;
        unique case (op)
            LW:      ldata = word;
            LH:      ldata = {{16{lh[15]}}, lh};
            LHU:     ldata = {16'h0, lh};
            LB:      ldata = {{24{lb[7]}}, lb};
            LBU:     ldata = {24'h0, lb};
            default: ldata = 32'h0;
        endcase
    end

    always_comb begin
        sdata = word;
        unique case (op)
            SW: sdata = wdata;
            SH: begin
                if (addr[1]) sdata[31:16] = wdata[15:0];
                else         sdata[15:0]  = wdata[15:0];
            end
            SB: begin
                unique case (addr)
                    2'd0: sdata[7:0]   = wdata[7:0];
                    2'd1: sdata[15:8]  = wdata[7:0];
                    2'd2: sdata[23:16] = wdata[7:0];
                    2'd3: sdata[31:24] = wdata[7:0];
                endcase
            end
            default: sdata = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for the word-addressed data memory.
// Optional misalignment trapping: define MEM_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    mau_state_t        state_q, state_d;
    mem_op_t           op_q;
    mem_op_t           op_in;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       ldata;
    logic [31:0]       sdata;
    logic              accept;
    logic              misal;

    assign op_in  = mem_op_t'(req_op);
    assign accept = req_valid && (state_q == IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;
    assign misal    = is_misaligned(op_in, req_addr[1:0]);
    assign resp_err = err_q;
`else
    assign misal    = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign resp_rdata = rdata_q;

    mem_lane_align u_align (
        .op    (op_q),
        .addr  (addr_q[1:0]),
        .word  (dm_dout),
        .wdata (wdata_q),
        .ldata (ldata),
        .sdata (sdata)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = addr_q[ADDR_W-1:2];
        dm_din     = sdata;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                dm_addr   = req_addr[ADDR_W-1:2];
                dm_din    = req_wdata;
                dm_we     = req_valid && (op_in == SW) && !misal;
                if (req_valid) begin
                    if (misal || (op_in == SW)) state_d = RESP;
                    else if (is_load(op_in))    state_d = LOAD;
                    else                        state_d = MERGE;
                end
            end
            LOAD: begin
                state_d = RESP;
            end
            MERGE: begin
                dm_we   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_in;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                err_q   <= misal;
`endif
            end
            if (state_q == LOAD) rdata_q <= ldata;
        end
    end

endmodule
